// File: rtl/rs_codeword_assembler_pkg.sv
// Shared RS(18,16) definitions: code geometry and the assembler state encoding.
package rs_codeword_assembler_pkg;

    localparam int unsigned RS_N            = 18;
    localparam int unsigned RS_SYMBOL_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StHold,
        StDiscard
    } asm_state_e;

endpackage

// File: rtl/rs_cw_outreg.sv
// Single-entry output register with valid flag feeding the syndrome stage.
module rs_cw_outreg
    import rs_codeword_assembler_pkg::*;
#(
    parameter int unsigned Width = RS_N * RS_SYMBOL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    input  logic             cw_ready,
    output logic             can_load,
    output logic             cw_valid,
    output logic [Width-1:0] cw_data
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    // Free now, or freed by the handshake completing this cycle.
    assign can_load = !valid_q || cw_ready;

    // Load a new codeword or retire the current one on handshake; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (cw_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign cw_valid = valid_q;
    assign cw_data  = data_q;

endmodule

// File: rtl/rs_codeword_assembler.sv
// Collects framed RS symbols into a full N-symbol codeword for the syndrome stage,
// dropping malformed frames with a one-cycle frame_err pulse.
module rs_codeword_assembler
    import rs_codeword_assembler_pkg::*;
#(
    parameter int unsigned N            = RS_N,
    parameter int unsigned SYMBOL_WIDTH = RS_SYMBOL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SYMBOL_WIDTH-1:0]   in_data,
    input  logic                      in_sop,
    input  logic                      in_eop,
    output logic                      cw_valid,
    input  logic                      cw_ready,
    output logic [N*SYMBOL_WIDTH-1:0] cw_data,
    output logic                      frame_err
);

    localparam int unsigned CwW  = N * SYMBOL_WIDTH;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    asm_state_e      st_q;
    logic [CntW-1:0] cnt_q;
    logic [CwW-1:0]  buf_q;
    logic            in_ready_q;
    logic            frame_err_q;

    logic            accept;
    logic            last;
    logic            complete;
    logic            out_can_load;
    logic            out_load;
    logic [CntW-1:0] slot;
    logic [CwW-1:0]  frame;
    logic [CwW-1:0]  load_data;

    assign accept = in_valid && in_ready_q;
    assign last   = (cnt_q == CntW'(N - 1));

    // Partial frame with the incoming symbol dropped into its slot; an sop always lands in slot 0.
    always_comb begin
        slot  = (st_q == StCollect && !in_sop) ? cnt_q : '0;
        frame = buf_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (slot == CntW'(i)) begin
                frame[(N - 1 - i) * SYMBOL_WIDTH +: SYMBOL_WIDTH] = in_data;
            end
        end
    end

    // Decide when the output register takes a codeword and from where.
    always_comb begin
        complete  = accept && (st_q == StCollect) && !in_sop && last && in_eop;
        out_load  = (complete && out_can_load) || ((st_q == StHold) && out_can_load);
        load_data = (st_q == StHold) ? buf_q : frame;
    end

    // Frame-parsing FSM with registered in_ready and frame_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= StIdle;
            cnt_q       <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            in_ready_q  <= 1'b1;
            unique case (st_q)
                StIdle, StDiscard: begin
                    if (accept) begin
                        if (in_sop && !in_eop) begin
                            buf_q <= frame;
                            cnt_q <= CntW'(1);
                            st_q  <= StCollect;
                        end else if (in_sop) begin
                            // A one-symbol frame can never be a full codeword.
                            frame_err_q <= 1'b1;
                            st_q        <= StIdle;
                        end else if (st_q == StIdle) begin
                            frame_err_q <= 1'b1;
                        end else if (in_eop) begin
                            st_q <= StIdle;
                        end
                    end
                end
                StCollect: begin
                    if (accept) begin
                        if (in_sop) begin
                            frame_err_q <= 1'b1;
                            if (in_eop) begin
                                cnt_q <= '0;
                                st_q  <= StIdle;
                            end else begin
                                buf_q <= frame;
                                cnt_q <= CntW'(1);
                            end
                        end else if (last) begin
                            cnt_q <= '0;
                            if (!in_eop) begin
                                frame_err_q <= 1'b1;
                                st_q        <= StDiscard;
                            end else if (out_can_load) begin
                                st_q <= StIdle;
                            end else begin
                                buf_q      <= frame;
                                st_q       <= StHold;
                                in_ready_q <= 1'b0;
                            end
                        end else if (in_eop) begin
                            frame_err_q <= 1'b1;
                            cnt_q       <= '0;
                            st_q        <= StIdle;
                        end else begin
                            buf_q <= frame;
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_can_load) begin
                        st_q <= StIdle;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    rs_cw_outreg #(
        .Width (CwW)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (load_data),
        .cw_ready  (cw_ready),
        .can_load  (out_can_load),
        .cw_valid  (cw_valid),
        .cw_data   (cw_data)
    );

    assign in_ready  = in_ready_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rs_codeword_assembler.sv
// Randomized and directed bench for rs_codeword_assembler against a frame-level model.
module tb_rs_codeword_assembler;
    import rs_codeword_assembler_pkg::*;

    localparam int unsigned N  = RS_N;
    localparam int unsigned W  = RS_SYMBOL_WIDTH;
    localparam int unsigned CW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          cw_valid;
    logic          cw_ready = 1'b1;
    logic [CW-1:0] cw_data;
    logic          frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_err    = 0;
    int n_cw     = 0;
    int n_stall  = 0;
    bit rand_ready = 1'b0;

    // Frame-level reference model state.
    logic [W-1:0]  m_frame[$];
    logic [CW-1:0] exp_q[$];
    bit            m_open    = 1'b0;
    bit            m_discard = 1'b0;
    bit            exp_err   = 1'b0;
    bit            had_stall = 1'b0;
    logic [CW-1:0] held_data = '0;
    logic [CW-1:0] last_cw   = '0;

    rs_codeword_assembler #(
        .N            (N),
        .SYMBOL_WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_data   (cw_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Symbol k of a codeword sits k symbols below the top.
    function automatic logic [CW-1:0] pack_frame();
        logic [CW-1:0] cw = '0;
        for (int k = 0; k < int'(N); k++) cw[(N - k) * W - 1 -: W] = m_frame[k];
        return cw;
    endfunction

    function automatic logic [CW-1:0] build_cw(input int base);
        logic [CW-1:0] cw = '0;
        for (int k = 0; k < int'(N); k++) cw[(N - k) * W - 1 -: W] = W'(base + k);
        return cw;
    endfunction

    task automatic model_accept(input logic [W-1:0] d, input bit sop, input bit eop,
                                output bit err);
        err = 1'b0;
        if (sop) begin
            if (m_open) err = 1'b1;
            m_discard = 1'b0;
            m_frame.delete();
            m_frame.push_back(d);
            m_open = 1'b1;
            if (eop) begin
                err    = 1'b1;
                m_open = 1'b0;
            end
        end else if (m_discard) begin
            if (eop) m_discard = 1'b0;
        end else if (!m_open) begin
            err = 1'b1;
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == N) begin
                m_open = 1'b0;
                if (eop) exp_q.push_back(pack_frame());
                else begin
                    err       = 1'b1;
                    m_discard = 1'b1;
                end
            end else if (eop) begin
                err    = 1'b1;
                m_open = 1'b0;
            end
        end
    endtask

    // Monitor: per-cycle frame_err timing, output ordering/content and stall stability.
    always @(negedge clk) begin
        bit e;
        if (reset) begin
            m_frame.delete();
            exp_q.delete();
            m_open    = 1'b0;
            m_discard = 1'b0;
            exp_err   = 1'b0;
            had_stall = 1'b0;
        end else begin
            check_eq("frame_err", CW'(frame_err), CW'(exp_err));
            if (had_stall) begin
                check_eq("stall_valid", CW'(cw_valid), CW'(1));
                check_eq("stall_data", cw_data, held_data);
            end
            if (cw_valid && cw_ready) begin
                if (exp_q.size() == 0) check_eq("cw_spurious", CW'(cw_valid), CW'(0));
                else check_eq("cw_data", cw_data, exp_q.pop_front());
                last_cw = cw_data;
                n_cw++;
            end
            if (frame_err) n_err++;
            had_stall = cw_valid && !cw_ready;
            held_data = cw_data;
            e = 1'b0;
            if (in_valid && in_ready) model_accept(in_data, in_sop, in_eop, e);
            exp_err = e;
        end
    end

    task automatic tick();
        if (rand_ready) cw_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_sym(input logic [W-1:0] d, input bit sop, input bit eop);
        bit done = 1'b0;
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        while (!done) begin
            if (rand_ready) cw_ready = 1'($urandom_range(0, 1));
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                n_stall++;
                if (waited > 200) begin
                    check_eq("in_ready_timeout", CW'(in_ready), CW'(1));
                    done = 1'b1;
                end
            end
        end
        // Junk on the bus while invalid must be ignored.
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_sop   = 1'($urandom_range(0, 1));
        in_eop   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_good(input int base);
        for (int i = 0; i < int'(N); i++) send_sym(W'(base + i), i == 0, i == int'(N) - 1);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, c0, s0, kind, len, part;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", CW'(in_ready), CW'(0));
        check_eq("rst_cw_valid", CW'(cw_valid), CW'(0));
        check_eq("rst_frame_err", CW'(frame_err), CW'(0));
        check_eq("rst_cw_data", cw_data, CW'(0));
        reset = 1'b0;
        tick();
        check_eq("post_rst_in_ready", CW'(in_ready), CW'(1));

        // Basic frame plus a back-to-back second frame with no stalls.
        cw_ready = 1'b1;
        s0 = n_stall;
        send_good(8'h01);
        check_eq("basic_valid", CW'(cw_valid), CW'(1));
        check_eq("basic_sym0", CW'(cw_data[CW-1 -: W]), CW'(8'h01));
        check_eq("basic_sym17", CW'(cw_data[W-1:0]), CW'(8'h12));
        send_good(8'h21);
        check_eq("b2b_valid", CW'(cw_valid), CW'(1));
        check_eq("b2b_data", cw_data, build_cw(8'h21));
        check_eq("b2b_stalls", CW'(n_stall - s0), CW'(0));
        idle(2);

        // Backpressure: first frame held, second parked in HOLD.
        cw_ready = 1'b0;
        send_good(8'h40);
        send_good(8'h80);
        check_eq("hold_in_ready", CW'(in_ready), CW'(0));
        check_eq("hold_valid", CW'(cw_valid), CW'(1));
        check_eq("hold_data_a", cw_data, build_cw(8'h40));
        idle(3);
        check_eq("hold_in_ready2", CW'(in_ready), CW'(0));
        check_eq("hold_data_a2", cw_data, build_cw(8'h40));
        cw_ready = 1'b1;
        @(posedge clk);
        #1;
        cw_ready = 1'b0;
        check_eq("release_valid", CW'(cw_valid), CW'(1));
        check_eq("release_data_b", cw_data, build_cw(8'h80));
        check_eq("release_in_ready", CW'(in_ready), CW'(1));
        cw_ready = 1'b1;
        idle(2);

        // Short frame: eop on symbol 17.
        e0 = n_err; c0 = n_cw;
        for (int i = 0; i < int'(N) - 1; i++) send_sym(W'(8'h50 + i), i == 0, i == int'(N) - 2);
        idle(3);
        check_eq("short_err", CW'(n_err - e0), CW'(1));
        check_eq("short_cw", CW'(n_cw - c0), CW'(0));

        // Restart on symbol 5.
        e0 = n_err; c0 = n_cw;
        for (int i = 0; i < 4; i++) send_sym(W'(8'h60 + i), i == 0, 1'b0);
        send_good(8'h90);
        idle(3);
        check_eq("restart_err", CW'(n_err - e0), CW'(1));
        check_eq("restart_cw", CW'(n_cw - c0), CW'(1));
        check_eq("restart_data", last_cw, build_cw(8'h90));

        // Overlong frame: 20 symbols, eop on the 20th.
        e0 = n_err; c0 = n_cw;
        for (int i = 0; i < 20; i++) begin
            send_sym(W'(8'hc0 + i), i == 0, i == 19);
            if (i == int'(N) - 1) check_eq("long_err_pulse", CW'(frame_err), CW'(1));
        end
        idle(3);
        check_eq("long_err", CW'(n_err - e0), CW'(1));
        check_eq("long_cw", CW'(n_cw - c0), CW'(0));
        send_good(8'ha0);
        idle(3);
        check_eq("after_long_cw", CW'(n_cw - c0), CW'(1));
        check_eq("after_long_data", last_cw, build_cw(8'ha0));

        // Reset mid-collect.
        e0 = n_err; c0 = n_cw;
        for (int i = 0; i < 9; i++) send_sym(W'(8'h70 + i), i == 0, 1'b0);
        reset = 1'b1;
        idle(2);
        check_eq("midrst_valid", CW'(cw_valid), CW'(0));
        check_eq("midrst_err", CW'(frame_err), CW'(0));
        check_eq("midrst_in_ready", CW'(in_ready), CW'(0));
        reset = 1'b0;
        tick();
        check_eq("midrst_ready_back", CW'(in_ready), CW'(1));
        send_good(8'hb0);
        idle(3);
        check_eq("midrst_no_err", CW'(n_err - e0), CW'(0));
        check_eq("midrst_cw", CW'(n_cw - c0), CW'(1));
        check_eq("midrst_data", last_cw, build_cw(8'hb0));

        // Randomized mix of good and malformed frames under random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            len  = int'(N);
            if (kind == 6) len = $urandom_range(1, N - 1);
            if (kind == 7) len = $urandom_range(N + 1, N + 3);
            if (kind == 8) begin
                part = $urandom_range(1, N - 1);
                for (int i = 0; i < part; i++) send_sym(W'($urandom), i == 0, 1'b0);
            end
            if (kind == 9) send_sym(W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < len; i++) begin
                send_sym(W'($urandom), i == 0, i == len - 1);
                if ($urandom_range(0, 7) == 0) idle(1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rand_ready = 1'b0;
        cw_ready   = 1'b1;
        idle(5);
        check_eq("cw_drain", CW'(exp_q.size()), CW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
